// File: rtl/serial_as_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
// Holds the control FSM encoding and the operation-select codes.
package serial_as_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/fa_fs_bit.sv
// Single-bit full adder / full subtractor cell, purely combinational.
// The sum/difference bit is identical for both modes; only the carry-out differs.
module fa_fs_bit
    import serial_as_pkg::*;
(
    input  logic x,
    input  logic y,
    input  logic c,
    input  logic mode,
    output logic s,
    output logic c_out
);

    // Borrow is the carry equation with the minuend bit inverted.
    logic x_eff;

    assign x_eff = (mode == MODE_SUB) ? ~x : x;
    assign s     = x ^ y ^ c;
    assign c_out = (x_eff & y) | (y & c) | (c & x_eff);

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one bit per clock, LSB first, through a single
// bit cell with a registered carry/borrow. done pulses one cycle after the last bit.
module serial_add_sub
    import serial_as_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               mode_q;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   result_q;
    logic               cout_q;
    logic               bit_s;
    logic               bit_c;
    logic               last_bit;

    assign last_bit = (cnt_q == CNT_LAST);

    fa_fs_bit u_cell (
        .x     (a_q[0]),
        .y     (b_q[0]),
        .c     (carry_q),
        .mode  (mode_q),
        .s     (bit_s),
        .c_out (bit_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            SHIFT:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Operands shift out LSB first while result bits enter at the MSB end,
    // so after WIDTH cycles result holds the full word in natural order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            mode_q   <= MODE_ADD;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q      <= a;
                        b_q      <= b;
                        mode_q   <= mode;
                        carry_q  <= 1'b0;
                        cnt_q    <= '0;
                        result_q <= '0;
                    end
                end
                SHIFT: begin
                    result_q <= {bit_s, result_q[WIDTH-1:1]};
                    a_q      <= {1'b0, a_q[WIDTH-1:1]};
                    b_q      <= {1'b0, b_q[WIDTH-1:1]};
                    carry_q  <= bit_c;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (last_bit) begin
                        cout_q <= bit_c;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result = result_q;
    assign cout   = cout_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Self-checking bench for serial_add_sub (WIDTH=8): directed corner cases plus
// random operations compared against a plain-arithmetic reference model.
module tb_serial_add_sub;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic         mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;

    int n_checks;
    int n_errors;
    int cyc;
    int last_done_cyc;
    int prev_done_cyc;

    serial_add_sub #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .mode   (mode),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: (W+1)-bit arithmetic; bit W is the carry for add, borrow for sub.
    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic m);
        logic [W:0] r;
        if (m) r = {1'b0, x} - {1'b0, y};
        else   r = {1'b0, x} + {1'b0, y};
        return r;
    endfunction

    // Issues one operation and follows it cycle by cycle. Ends while observing
    // the expected done cycle, so a following call starts on the first IDLE cycle.
    task automatic run_op(input string tag, input logic [W-1:0] ai, input logic [W-1:0] bi,
                          input logic mi, input bit poke);
        logic [W:0] exp;
        int busy_cnt;
        int done_cnt;
        int done_k;
        exp = model(ai, bi, mi);
        @(negedge clk);
        a = ai; b = bi; mode = mi; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); mode = 1'($urandom);
        busy_cnt = 0; done_cnt = 0; done_k = -1;
        for (int k = 1; k <= W + 1; k++) begin
            if (k > 1) @(negedge clk);
            if (poke && k == 3) begin
                start = 1'b1; a = 8'hAA; b = 8'h55; mode = ~mi;
            end
            if (poke && k == 4) start = 1'b0;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_k = k;
                prev_done_cyc = last_done_cyc;
                last_done_cyc = cyc;
            end
        end
        check_eq({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(W));
        check_eq({tag, "_done_cycle"}, 64'(done_k), 64'(W + 1));
        check_eq({tag, "_done_count"}, 64'(done_cnt), 64'd1);
        check_eq({tag, "_result"}, 64'(result), 64'(exp[W-1:0]));
        check_eq({tag, "_cout"}, 64'(cout), 64'(exp[W]));
    endtask

    initial begin
        logic [W:0] exp;
        int extra_done;
        n_checks = 0; n_errors = 0; cyc = 0;
        last_done_cyc = 0; prev_done_cyc = 0;
        rst = 1'b1; start = 1'b0; mode = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_result", 64'(result), 64'd0);
        check_eq("rst_cout", 64'(cout), 64'd0);
        rst = 1'b0;

        run_op("add_5a_33", 8'h5A, 8'h33, 1'b0, 1'b0);
        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0);
        run_op("sub_10_01", 8'h10, 8'h01, 1'b1, 1'b0);
        run_op("sub_01_02", 8'h01, 8'h02, 1'b1, 1'b0);

        // start pulsed mid-operation must be ignored and not queued
        run_op("busy_prot", 8'h5A, 8'h33, 1'b0, 1'b1);
        extra_done = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done || busy) extra_done++;
        end
        check_eq("busy_prot_no_requeue", 64'(extra_done), 64'd0);
        check_eq("hold_result", 64'(result), 64'h8D);
        check_eq("hold_cout", 64'(cout), 64'd0);

        // back-to-back: second start on the first IDLE cycle after done
        run_op("b2b_first", 8'h81, 8'h7F, 1'b0, 1'b0);
        run_op("b2b_second", 8'h33, 8'h44, 1'b1, 1'b0);
        check_eq("b2b_done_spacing", 64'(last_done_cyc - prev_done_cyc), 64'd10);

        // asynchronous abort during shift cycle 4
        @(negedge clk);
        a = 8'h5A; b = 8'h33; mode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("abort_pre_busy", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("abort_busy", 64'(busy), 64'd0);
        check_eq("abort_done", 64'(done), 64'd0);
        check_eq("abort_result", 64'(result), 64'd0);
        check_eq("abort_cout", 64'(cout), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        extra_done = 0;
        for (int k = 0; k < W + 4; k++) begin
            @(negedge clk);
            if (done || busy) extra_done++;
        end
        check_eq("abort_no_done", 64'(extra_done), 64'd0);
        run_op("after_abort", 8'h02, 8'h03, 1'b0, 1'b0);

        // random operations, including operand changes after the start edge
        for (int i = 0; i < 24; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = W'($urandom);
            rb = W'($urandom);
            if (i == 0) begin ra = '0; rb = '0; end
            if (i == 1) begin ra = '1; rb = '1; end
            run_op($sformatf("rand%0d", i), ra, rb, 1'($urandom), 1'($urandom_range(0, 3) == 0));
        end

        exp = model(8'h00, 8'h01, 1'b1);
        run_op("sub_00_01", 8'h00, 8'h01, 1'b1, 1'b0);
        check_eq("sub_00_01_model_borrow", 64'(cout), 64'(exp[W]));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

endmodule

// File: doc/serial_add_sub.md
SERIAL_ADD_SUB -- requirements
Module: serial_add_sub

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  request a new operation; sampled only in IDLE.
REQ-005 mode  input  1  operation select: 0 = add (a+b), 1 = subtract (a-b).
REQ-006 a  input  WIDTH  first operand (minuend for subtract).
REQ-007 b  input  WIDTH  second operand (subtrahend for subtract).
REQ-008 busy  output  1  high while an operation is in progress (state SHIFT).
REQ-009 done  output  1  single-cycle pulse: result and cout are valid.
REQ-010 result  output  WIDTH  sum or difference, modulo 2^WIDTH.
REQ-011 cout  output  1  final carry (add) or final borrow (subtract).

Function
REQ-012 The block shall be a bit-serial adder/subtractor: one bit per clock, LSB first, through a single full-adder/full-subtractor bit cell with a registered carry/borrow.
REQ-013 FSM states shall be IDLE, SHIFT and DONE.
REQ-014 IDLE -> SHIFT when start=1: latch a, b and mode into internal registers, clear the carry/borrow flop, clear the bit counter, and clear result.
REQ-015 In IDLE, start=0 shall leave the state in IDLE and hold result, cout and done=0.
REQ-016 In each SHIFT cycle, bit i shall be computed from the latched operand LSBs x and y and the stored carry/borrow c.
REQ-017 For add, the result bit shall be x^y^c and the new carry shall be (x&y)|(y&c)|(c&x).
REQ-018 For subtract, the result bit shall be x^y^c and the new borrow shall be (~x&y)|(y&c)|(c&~x).
REQ-019 The result bit shall enter result at the MSB end with result shifted right one place; both operand registers shall shift right one place.
REQ-020 SHIFT -> DONE after exactly WIDTH shift cycles (bit counter reaches WIDTH-1).
REQ-021 On the SHIFT -> DONE transition, cout shall capture the final carry/borrow.
REQ-022 DONE -> IDLE unconditionally after one cycle; done=1 only in DONE.
REQ-023 Latency: if start is sampled at edge E0, done shall be high for exactly the cycle after edge E(WIDTH).
REQ-024 start in SHIFT or DONE shall be ignored; no queuing, and latched operands shall be unaffected.
REQ-025 mode, a and b changes after the start edge shall not affect the operation in flight.
REQ-026 result and cout shall hold their values from the DONE cycle until the next accepted start.

Reset
REQ-027 While rst=1: state=IDLE, busy=0, done=0, result=0, cout=0, and operand, counter and carry registers=0, independent of clk.
REQ-028 Reset asserted mid-operation shall abort with no done pulse; the first start after rst deasserts shall begin a fresh operation.

Structure
REQ-029 A shared package serial_as_pkg shall hold the FSM state type (IDLE/SHIFT/DONE) and the constants MODE_ADD=0 and MODE_SUB=1.
REQ-030 The bit cell shall be a separate combinational sub-module, fa_fs_bit, with inputs x, y, c, mode and outputs s and c_out.
REQ-031 The counter width shall be $clog2(WIDTH).

Verification (WIDTH=8)
REQ-032 Add: a=0x5A, b=0x33, mode=0, start -> done in cycle 9 after start edge, result=0x8D, cout=0; busy high for cycles 1-8.
REQ-033 Add overflow: a=0xFF, b=0x01, mode=0 -> result=0x00, cout=1.
REQ-034 Subtract: 0x10-0x01 -> result=0x0F, cout=0; 0x01-0x02 -> result=0xFF, cout(borrow)=1.
REQ-035 Abort: start add 0x5A+0x33, assert rst at shift cycle 4 -> all outputs 0 immediately, no done pulse; then 0x02+0x03 -> result=0x05.
REQ-036 Busy protection: pulse start with a=0xAA, b=0x55 during SHIFT of 0x5A+0x33 -> result still 0x8D, exactly one done pulse.
REQ-037 Back-to-back: assert start on the first IDLE cycle after done -> second result correct, done pulses 10 cycles apart.
